// File: rtl/adc_ram_reader_if.sv
// Capture-RAM read port plus the unpacked sample stream.
// The reader drives this through the master modport; the RAM and stream sink use the slave modport.
interface adc_ram_reader_if #(
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0] oRAddr;
    logic              oRDEN;
    logic [127:0]      iRAMData;
    logic              oSampleValid;
    logic              iSampleReady;
    logic [95:0]       oSampleData;
    logic [15:0]       oSampleIndex;

    modport master (
        output oRAddr,
        output oRDEN,
        input  iRAMData,
        output oSampleValid,
        input  iSampleReady,
        output oSampleData,
        output oSampleIndex
    );

    modport slave (
        input  oRAddr,
        input  oRDEN,
        output iRAMData,
        input  oSampleValid,
        output iSampleReady,
        input  oSampleData,
        input  oSampleIndex
    );
endinterface

// File: rtl/adc_ram_reader.sv
// Reads back 128-bit ADC capture words and emits one 8 x 12-bit timepoint per beat.
// Handles both the 16-bit-slot (uncompressed) layout and the 3-word/4-timepoint packed layout.
module adc_ram_reader #(
    parameter int ADDR_W    = 15,
    parameter int MAX_WORDS = 16384
) (
    input  logic             sys_clk,
    input  logic             iReset,
    input  logic             iStart,
    input  logic             iAbort,
    input  logic [15:0]      iRecLength,
    input  logic             iCompressed,
    adc_ram_reader_if.master bus,
    output logic             oBusy,
    output logic             oDone,
    output logic             oLenError
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [15:0]       w_lenClamp;
    logic [15:0]       w_rem;
    logic [15:0]       w_readLen;
    logic              w_start;
    logic              w_rden;
    logic              w_valid;
    logic              w_fire;
    logic              w_lastFetch;
    logic              w_lastBeat;
    logic [383:0]      w_groupFlat;
    logic [95:0]       w_data;

    logic              r_compressed;
    logic [ADDR_W-1:0] r_wordCnt;
    logic [15:0]       r_wordsLeft;
    logic [1:0]        r_fetchCnt;
    logic [1:0]        r_beat;
    logic [15:0]       r_index;
    logic [127:0]      r_group [3];
    logic              r_rdValid;
    logic [1:0]        r_rdSlot;
    logic              r_remNz;
    logic              r_lenError;

    // Packed mode only reads whole 3-word groups; the remainder is skipped and flagged.
    assign w_lenClamp  = (iRecLength > 16'(MAX_WORDS)) ? 16'(MAX_WORDS) : iRecLength;
    assign w_rem       = w_lenClamp % 16'd3;
    assign w_readLen   = iCompressed ? (w_lenClamp - w_rem) : w_lenClamp;
    assign w_start     = iStart && !iAbort && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_fire      = w_valid && bus.iSampleReady;
    assign w_lastFetch = (r_fetchCnt == (r_compressed ? 2'd2 : 2'd0));
    assign w_lastBeat  = !r_compressed || (r_beat == 2'd3);
    assign w_groupFlat = {r_group[2], r_group[1], r_group[0]};

    always_ff @(posedge sys_clk or posedge iReset) begin
        if (iReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_rden      = 1'b0;
        w_valid     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start) begin
                    w_nextState = (w_readLen == 16'd0) ? S_DONE : S_FETCH;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            S_FETCH: begin
                w_rden = 1'b1;
                if (w_lastFetch) begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                w_nextState = S_EMIT;
            end
            S_EMIT: begin
                w_valid = 1'b1;
                if (w_fire && w_lastBeat) begin
                    w_nextState = (r_wordsLeft != 16'd0) ? S_FETCH : S_DONE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
        if (iAbort) begin
            w_nextState = S_IDLE;
        end
    end

    // Read data lands one cycle after its enable, so the slot travels alongside it.
    always_ff @(posedge sys_clk or posedge iReset) begin
        if (iReset) begin
            r_compressed <= 1'b0;
            r_wordCnt    <= '0;
            r_wordsLeft  <= '0;
            r_fetchCnt   <= '0;
            r_beat       <= '0;
            r_index      <= '0;
            r_group[0]   <= '0;
            r_group[1]   <= '0;
            r_group[2]   <= '0;
            r_rdValid    <= 1'b0;
            r_rdSlot     <= '0;
            r_remNz      <= 1'b0;
            r_lenError   <= 1'b0;
        end else begin
            r_rdValid <= w_rden && !iAbort;
            r_rdSlot  <= r_fetchCnt;
            if (r_rdValid) begin
                case (r_rdSlot)
                    2'd0:    r_group[0] <= bus.iRAMData;
                    2'd1:    r_group[1] <= bus.iRAMData;
                    default: r_group[2] <= bus.iRAMData;
                endcase
            end
            if (w_start) begin
                r_compressed <= iCompressed;
                r_wordCnt    <= '0;
                r_wordsLeft  <= w_readLen;
                r_fetchCnt   <= '0;
                r_beat       <= '0;
                r_index      <= '0;
                r_remNz      <= iCompressed && (w_rem != 16'd0);
                r_lenError   <= (w_readLen == 16'd0) && iCompressed && (w_rem != 16'd0);
            end else begin
                if (w_rden) begin
                    r_wordsLeft <= r_wordsLeft - 16'd1;
                    if (r_wordsLeft != 16'd1) begin
                        r_wordCnt <= r_wordCnt + 1'b1;
                    end
                    r_fetchCnt <= w_lastFetch ? 2'd0 : (r_fetchCnt + 2'd1);
                end
                if (w_fire) begin
                    r_index <= r_index + 16'd1;
                    r_beat  <= w_lastBeat ? 2'd0 : (r_beat + 2'd1);
                end
                if ((r_state == S_EMIT) && (w_nextState == S_DONE)) begin
                    r_lenError <= r_remNz;
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        if (w_valid) begin
            if (r_compressed) begin
                case (r_beat)
                    2'd0:    w_data = w_groupFlat[95:0];
                    2'd1:    w_data = w_groupFlat[191:96];
                    2'd2:    w_data = w_groupFlat[287:192];
                    default: w_data = w_groupFlat[383:288];
                endcase
            end else begin
                for (int c = 0; c < 8; c++) begin
                    w_data[12*c +: 12] = r_group[0][16*c +: 12];
                end
            end
        end
    end

    assign bus.oRAddr       = r_wordCnt;
    assign bus.oRDEN        = w_rden;
    assign bus.oSampleValid = w_valid;
    assign bus.oSampleData  = w_data;
    assign bus.oSampleIndex = r_index;
    assign oBusy            = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_EMIT);
    assign oDone            = (r_state == S_DONE);
    assign oLenError        = r_lenError;
endmodule

// File: tb/tb_adc_ram_reader.sv
// Directed bench for adc_ram_reader: a one-cycle-latency RAM model, directed readouts,
// and expected beats/timing worked out by hand from the stimulus patterns.
module tb_adc_ram_reader;
    logic        clk = 1'b0;
    logic        iReset;
    logic        iStart;
    logic        iAbort;
    logic [15:0] iRecLength;
    logic        iCompressed;
    logic        oBusy;
    logic        oDone;
    logic        oLenError;

    adc_ram_reader_if #(.ADDR_W(15)) bus ();

    logic [127:0] mem [16];
    logic [127:0] ramData;

    int checkCount = 0;
    int passCount  = 0;

    logic [95:0] beatData [$];
    logic [15:0] beatIdx  [$];
    int          beatCyc  [$];
    int          addrQ    [$];
    int          firstValid;
    int          doneCyc;
    int          stallBad;
    int          cyc;
    int          doneSeen;
    logic        lenErrAtDone;
    logic        busyAtDone;

    adc_ram_reader #(.ADDR_W(15), .MAX_WORDS(16384)) dut (
        .sys_clk     (clk),
        .iReset      (iReset),
        .iStart      (iStart),
        .iAbort      (iAbort),
        .iRecLength  (iRecLength),
        .iCompressed (iCompressed),
        .bus         (bus),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oLenError   (oLenError)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.oRDEN) ramData <= mem[4'(bus.oRAddr)];
    end
    assign bus.iRAMData = ramData;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Eight 12-bit channels holding base+0 .. base+7.
    function automatic logic [95:0] expBeat(input int base);
        logic [95:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v[12*c +: 12] = 12'(base + c);
        return v;
    endfunction

    task automatic applyStimulus(input logic [15:0] len, input logic comp);
        @(negedge clk);
        iStart      = 1'b1;
        iRecLength  = len;
        iCompressed = comp;
        @(negedge clk);
        iStart = 1'b0;
    endtask

    // cyc counts negedges after the start edge; ready is high when cyc % readyPeriod == 0.
    task automatic runReadout(input logic [15:0] len, input logic comp, input int readyPeriod, input int budget);
        logic        ready;
        logic        prevStalled;
        logic [95:0] prevData;
        logic [15:0] prevIdx;
        beatData.delete();
        beatIdx.delete();
        beatCyc.delete();
        addrQ.delete();
        firstValid   = -1;
        doneCyc      = -1;
        stallBad     = 0;
        lenErrAtDone = 1'b0;
        busyAtDone   = 1'b1;
        prevStalled  = 1'b0;
        prevData     = '0;
        prevIdx      = '0;
        applyStimulus(len, comp);
        cyc = 1;
        while (doneCyc < 0 && cyc <= budget) begin
            ready = (readyPeriod <= 1) ? 1'b1 : ((cyc % readyPeriod) == 0);
            bus.iSampleReady = ready;
            if (bus.oRDEN) addrQ.push_back(int'(bus.oRAddr));
            if (bus.oSampleValid) begin
                if (firstValid < 0) firstValid = cyc;
                if (prevStalled && (bus.oSampleData !== prevData || bus.oSampleIndex !== prevIdx)) stallBad++;
                if (ready) begin
                    beatData.push_back(bus.oSampleData);
                    beatIdx.push_back(bus.oSampleIndex);
                    beatCyc.push_back(cyc);
                end
                prevStalled = !ready;
                prevData    = bus.oSampleData;
                prevIdx     = bus.oSampleIndex;
            end else begin
                if (prevStalled) stallBad++;
                prevStalled = 1'b0;
            end
            if (oDone) begin
                doneCyc      = cyc;
                lenErrAtDone = oLenError;
                busyAtDone   = oBusy;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.iSampleReady = 1'b1;
    endtask

    initial begin
        iReset           = 1'b1;
        iStart           = 1'b0;
        iAbort           = 1'b0;
        iRecLength       = '0;
        iCompressed      = 1'b0;
        bus.iSampleReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            for (int c = 0; c < 8; c++) mem[i][16*c +: 16] = 16'hF000 | 16'(i*16 + c);
        end

        repeat (2) @(negedge clk);
        checkOutput("reset oRAddr", 128'(bus.oRAddr), 128'(0));
        checkOutput("reset oRDEN", 128'(bus.oRDEN), 128'(0));
        checkOutput("reset oSampleValid", 128'(bus.oSampleValid), 128'(0));
        checkOutput("reset oSampleData", 128'(bus.oSampleData), 128'(0));
        checkOutput("reset oSampleIndex", 128'(bus.oSampleIndex), 128'(0));
        checkOutput("reset oBusy", 128'(oBusy), 128'(0));
        checkOutput("reset oDone", 128'(oDone), 128'(0));
        checkOutput("reset oLenError", 128'(oLenError), 128'(0));
        iReset = 1'b0;
        @(negedge clk);

        $display("[TB] uncompressed L=4");
        runReadout(16'd4, 1'b0, 1, 40);
        checkOutput("u4 beat count", 128'(beatData.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("u4 beat%0d data", i), 128'(beatData[i]), 128'(expBeat(i*16)));
            checkOutput($sformatf("u4 beat%0d index", i), 128'(beatIdx[i]), 128'(i));
            checkOutput($sformatf("u4 beat%0d cycle", i), 128'(beatCyc[i]), 128'(3 + 3*i));
            checkOutput($sformatf("u4 addr%0d", i), 128'(addrQ[i]), 128'(i));
        end
        checkOutput("u4 rden count", 128'(addrQ.size()), 128'(4));
        checkOutput("u4 first valid", 128'(firstValid), 128'(3));
        checkOutput("u4 done cycle", 128'(doneCyc), 128'(13));
        checkOutput("u4 busy at done", 128'(busyAtDone), 128'(0));

        $display("[TB] L=0");
        runReadout(16'd0, 1'b0, 1, 10);
        checkOutput("l0 done cycle", 128'(doneCyc), 128'(1));
        checkOutput("l0 rden count", 128'(addrQ.size()), 128'(0));
        checkOutput("l0 valid seen", 128'(firstValid), 128'(-1));

        $display("[TB] abort in beat 1 of uncompressed L=10");
        applyStimulus(16'd10, 1'b0);
        cyc = 1;
        while (!(bus.oSampleValid && bus.oSampleIndex == 16'd1) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("abort reached beat1 cycle", 128'(cyc), 128'(6));
        iAbort = 1'b1;
        @(negedge clk);
        iAbort = 1'b0;
        checkOutput("abort valid", 128'(bus.oSampleValid), 128'(0));
        checkOutput("abort busy", 128'(oBusy), 128'(0));
        checkOutput("abort rden", 128'(bus.oRDEN), 128'(0));
        doneSeen = int'(oDone);
        repeat (5) begin
            @(negedge clk);
            if (oDone) doneSeen++;
        end
        checkOutput("abort no done", 128'(doneSeen), 128'(0));
        runReadout(16'd2, 1'b0, 1, 30);
        checkOutput("restart first addr", 128'(addrQ[0]), 128'(0));
        checkOutput("restart first index", 128'(beatIdx[0]), 128'(0));
        checkOutput("restart first data", 128'(beatData[0]), 128'(expBeat(0)));
        checkOutput("restart done cycle", 128'(doneCyc), 128'(7));

        // Packed ramp: group g, timepoint k, channel c holds g*32 + k*8 + c.
        for (int g = 0; g < 5; g++) begin
            logic [383:0] grp;
            grp = '0;
            for (int k = 0; k < 4; k++)
                for (int c = 0; c < 8; c++) grp[96*k + 12*c +: 12] = 12'(g*32 + k*8 + c);
            for (int j = 0; j < 3; j++) mem[3*g + j] = grp[128*j +: 128];
        end

        $display("[TB] compressed L=6");
        runReadout(16'd6, 1'b1, 1, 60);
        checkOutput("c6 beat count", 128'(beatData.size()), 128'(8));
        for (int b = 0; b < 8; b++) begin
            checkOutput($sformatf("c6 beat%0d data", b), 128'(beatData[b]), 128'(expBeat(b*8)));
            checkOutput($sformatf("c6 beat%0d index", b), 128'(beatIdx[b]), 128'(b));
        end
        checkOutput("c6 first valid", 128'(firstValid), 128'(5));
        checkOutput("c6 done cycle", 128'(doneCyc), 128'(17));
        checkOutput("c6 lenError", 128'(lenErrAtDone), 128'(0));

        $display("[TB] compressed L=7");
        runReadout(16'd7, 1'b1, 1, 60);
        checkOutput("c7 beat count", 128'(beatData.size()), 128'(8));
        checkOutput("c7 rden count", 128'(addrQ.size()), 128'(6));
        checkOutput("c7 max addr", 128'(addrQ[addrQ.size()-1]), 128'(5));
        checkOutput("c7 last beat data", 128'(beatData[7]), 128'(expBeat(56)));
        checkOutput("c7 lenError at done", 128'(lenErrAtDone), 128'(1));

        $display("[TB] back-pressure compressed L=3");
        runReadout(16'd3, 1'b1, 3, 60);
        checkOutput("bp beat count", 128'(beatData.size()), 128'(4));
        for (int b = 0; b < 4; b++) begin
            checkOutput($sformatf("bp beat%0d data", b), 128'(beatData[b]), 128'(expBeat(b*8)));
            checkOutput($sformatf("bp beat%0d index", b), 128'(beatIdx[b]), 128'(b));
        end
        checkOutput("bp stall stability", 128'(stallBad), 128'(0));
        checkOutput("bp done cycle", 128'(doneCyc), 128'(16));
        checkOutput("bp lenError cleared", 128'(lenErrAtDone), 128'(0));

        $display("[TB] reset mid-FETCH");
        applyStimulus(16'd6, 1'b1);
        @(negedge clk);
        checkOutput("rst pre rden", 128'(bus.oRDEN), 128'(1));
        checkOutput("rst pre addr", 128'(bus.oRAddr), 128'(1));
        #2 iReset = 1'b1;
        #1;
        checkOutput("rst oRDEN", 128'(bus.oRDEN), 128'(0));
        checkOutput("rst oRAddr", 128'(bus.oRAddr), 128'(0));
        checkOutput("rst oBusy", 128'(oBusy), 128'(0));
        checkOutput("rst oSampleValid", 128'(bus.oSampleValid), 128'(0));
        checkOutput("rst oSampleIndex", 128'(bus.oSampleIndex), 128'(0));
        checkOutput("rst oDone", 128'(oDone), 128'(0));
        @(negedge clk);
        iReset = 1'b0;
        @(negedge clk);
        checkOutput("post rst valid", 128'(bus.oSampleValid), 128'(0));
        checkOutput("post rst busy", 128'(oBusy), 128'(0));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
